// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the match scoreboard: FSM states, score
// width and the binary-to-BCD split used by the display digit registers.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    LOCKOUT = 2'd1,
    WON     = 2'd2
  } state_e;

  localparam int SCORE_W = 7;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

  // Returns {tens, ones} for a score in 0..99; larger inputs clamp to 99.
  function automatic logic [7:0] bin2bcd(input logic [SCORE_W-1:0] bin);
    logic [SCORE_W-1:0] val;
    logic [SCORE_W-1:0] ones_full;
    logic [3:0]         tens;
    val  = (bin > SCORE_MAX) ? SCORE_MAX : bin;
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (val >= SCORE_W'(10 * i)) begin
        tens = 4'(i);
      end else begin
        tens = tens;
      end
    end
    ones_full = val - ({3'd0, tens} * 7'd10);
    return {tens, 4'd0} + {1'b0, ones_full};
  endfunction

endpackage

// File: rtl/scoreboard_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and a registered
// pulse issued on the same edge the debounced level rises.
module scoreboard_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise, then only accept a new level after it has held steadily.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= CNT_W'(0);
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
          level_r <= sync2_r;
          press_r <= sync2_r;
          cnt_r   <= CNT_W'(0);
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= CNT_W'(0);
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/scoreboard_match_ctrl.sv
// Match controller: debounced buttons in, point arbitration, win detection,
// display selection and registered BCD digits out to the segment decoders.
module scoreboard_match_ctrl
  import scoreboard_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int LOCKOUT_CYC  = 200,
  parameter int DISP_CYC     = 1000,
  parameter int HOLD_CYC     = 2000,
  parameter int WIN_SCORE    = 21,
  parameter int BLINK_CYC    = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_p1_i,
  input  logic       btn_p2_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       blank_o,
  output logic       disp_p2_o,
  output logic       point_o,
  output logic       game_over_o,
  output logic       winner_p2_o
);

  localparam int LOCK_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int DISP_W  = (DISP_CYC > 1)    ? $clog2(DISP_CYC)    : 1;
  localparam int HOLD_W  = (HOLD_CYC > 1)    ? $clog2(HOLD_CYC)    : 1;
  localparam int BLINK_W = (BLINK_CYC > 1)   ? $clog2(BLINK_CYC)   : 1;
  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

  logic level1_s, press1_s, level2_s, press2_s;

  scoreboard_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_p1_i),
    .level (level1_s),
    .press (press1_s)
  );

  scoreboard_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_p2 (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_p2_i),
    .level (level2_s),
    .press (press2_s)
  );

  state_e               state_r;
  logic [SCORE_W-1:0]   score1_r, score2_r;
  logic                 rr_p2_r;
  logic [LOCK_W-1:0]    lock_cnt_r;
  logic [DISP_W-1:0]    disp_cnt_r;
  logic [HOLD_W-1:0]    hold_cnt_r;
  logic [BLINK_W-1:0]   blink_cnt_r;
  logic                 disp_p2_r, blank_r, point_r, game_over_r, winner_p2_r;
  logic [3:0]           tens_r, ones_r;

  logic                 grant_s, grant_p2_s, tie_s, win_s, new_game_s, disp_wrap_s;
  logic [SCORE_W-1:0]   mine_s, other_s, new_score_s, disp_score_s;

  // Arbitration and win evaluation for the press seen this cycle.
  always_comb begin
    grant_s    = 1'b0;
    grant_p2_s = 1'b0;
    tie_s      = 1'b0;
    if (state_r == PLAY) begin
      if (press1_s && press2_s) begin
        grant_s    = 1'b1;
        grant_p2_s = rr_p2_r;
        tie_s      = 1'b1;
      end else if (press1_s || press2_s) begin
        grant_s    = 1'b1;
        grant_p2_s = press2_s;
      end else begin
        grant_s = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
    end
    mine_s       = grant_p2_s ? score2_r : score1_r;
    other_s      = grant_p2_s ? score1_r : score2_r;
    new_score_s  = (mine_s >= SCORE_MAX) ? SCORE_MAX : mine_s + SCORE_W'(1);
    win_s        = ((new_score_s >= WIN_S) &&
                    ({1'b0, new_score_s} >= ({1'b0, other_s} + 8'd2))) ||
                   (new_score_s == SCORE_MAX);
    disp_score_s = disp_p2_r ? score2_r : score1_r;
    disp_wrap_s  = (disp_cnt_r == DISP_W'(DISP_CYC - 1));
    new_game_s   = level1_s && level2_s && (hold_cnt_r == HOLD_W'(HOLD_CYC - 1));
  end

  // Both-held counter; any release restarts it, and it runs in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_r <= HOLD_W'(0);
    end else if (level1_s && level2_s && !new_game_s) begin
      hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
    end else begin
      hold_cnt_r <= HOLD_W'(0);
    end
  end

  // Match FSM; a completed two-button hold pre-empts any award that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || new_game_s) begin
      state_r     <= PLAY;
      score1_r    <= SCORE_W'(0);
      score2_r    <= SCORE_W'(0);
      rr_p2_r     <= 1'b0;
      lock_cnt_r  <= LOCK_W'(0);
      disp_cnt_r  <= DISP_W'(0);
      blink_cnt_r <= BLINK_W'(0);
      disp_p2_r   <= 1'b0;
      blank_r     <= 1'b0;
      point_r     <= 1'b0;
      game_over_r <= 1'b0;
      winner_p2_r <= 1'b0;
    end else begin
      point_r <= 1'b0;
      case (state_r)
        PLAY: begin
          if (grant_s) begin
            point_r    <= 1'b1;
            disp_p2_r  <= grant_p2_s;
            disp_cnt_r <= DISP_W'(0);
            lock_cnt_r <= LOCK_W'(0);
            if (grant_p2_s) begin
              score2_r <= new_score_s;
            end else begin
              score1_r <= new_score_s;
            end
            if (tie_s) begin
              rr_p2_r <= ~rr_p2_r;
            end else begin
              rr_p2_r <= rr_p2_r;
            end
            if (win_s) begin
              state_r     <= WON;
              game_over_r <= 1'b1;
              winner_p2_r <= grant_p2_s;
              blank_r     <= 1'b0;
              blink_cnt_r <= BLINK_W'(0);
            end else begin
              state_r <= LOCKOUT;
            end
          end else if (disp_wrap_s) begin
            disp_cnt_r <= DISP_W'(0);
            disp_p2_r  <= ~disp_p2_r;
          end else begin
            disp_cnt_r <= disp_cnt_r + DISP_W'(1);
          end
        end
        LOCKOUT: begin
          if (disp_wrap_s) begin
            disp_cnt_r <= DISP_W'(0);
            disp_p2_r  <= ~disp_p2_r;
          end else begin
            disp_cnt_r <= disp_cnt_r + DISP_W'(1);
          end
          if (lock_cnt_r == LOCK_W'(LOCKOUT_CYC - 1)) begin
            lock_cnt_r <= LOCK_W'(0);
            state_r    <= PLAY;
          end else begin
            lock_cnt_r <= lock_cnt_r + LOCK_W'(1);
          end
        end
        WON: begin
          disp_p2_r <= winner_p2_r;
          if (blink_cnt_r == BLINK_W'(BLINK_CYC - 1)) begin
            blink_cnt_r <= BLINK_W'(0);
            blank_r     <= ~blank_r;
          end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
          end
        end
        default: begin
          state_r <= PLAY;
        end
      endcase
    end
  end

  // Digits lag the selected score by one register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_r <= 4'd0;
      ones_r <= 4'd0;
    end else begin
      {tens_r, ones_r} <= bin2bcd(disp_score_s);
    end
  end

  assign tens_o      = tens_r;
  assign ones_o      = ones_r;
  assign blank_o     = blank_r;
  assign disp_p2_o   = disp_p2_r;
  assign point_o     = point_r;
  assign game_over_o = game_over_r;
  assign winner_p2_o = winner_p2_r;

endmodule
